// File: rtl/qpacket_pkg.sv
// Shared definitions for the Q-routing packet path: default widths, packet-type
// encodings, broadcast ID and the transmit FSM state encoding.
package qpacket_pkg;

  localparam int          DEF_WORD_WIDTH = 16;
  localparam int          DEF_ADDR_WIDTH = 11;
  localparam logic [15:0] DEF_BCAST_ID   = 16'hFFFF;

  localparam logic [2:0] PKT_HELLO = 3'd1;
  localparam logic [2:0] PKT_DATA  = 3'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_CMP,
    S_SEND,
    S_DONE
  } state_t;

endpackage

// File: rtl/qpacket_tx_qmax_tracker.sv
// Running-maximum tracker: holds the best Q-value seen so far and its owner ID.
// The first candidate always loads; ties keep the earlier candidate.
module qmax_tracker #(
  parameter int WORD_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cmp,
  input  logic                  first,
  input  logic [WORD_WIDTH-1:0] cand_q,
  input  logic [WORD_WIDTH-1:0] cand_id,
  output logic [WORD_WIDTH-1:0] best_q,
  output logic [WORD_WIDTH-1:0] best_id
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      best_q  <= '0;
      best_id <= '0;
    end else if (cmp && (first || (cand_q > best_q))) begin
      best_q  <= cand_q;
      best_id <= cand_id;
    end
  end

endmodule

// File: rtl/qpacket_tx.sv
// Transmit-side packet builder: snapshots local node state, optionally scans the
// neighbor table for the highest-Q next hop, then offers one packet via valid/ready.
module qpacket_tx
  import qpacket_pkg::*;
#(
  parameter int                    WORD_WIDTH = DEF_WORD_WIDTH,
  parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = DEF_BCAST_ID
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [2:0]            pkt_type,
  input  logic [WORD_WIDTH-1:0] my_id,
  input  logic [WORD_WIDTH-1:0] my_cluster_id,
  input  logic [WORD_WIDTH-1:0] my_energy,
  input  logic [WORD_WIDTH-1:0] my_qvalue,
  input  logic [WORD_WIDTH-1:0] m_neighbor_count,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WORD_WIDTH-1:0] m_source_id,
  input  logic [WORD_WIDTH-1:0] m_qvalue,
  output logic [WORD_WIDTH-1:0] f_source_id,
  output logic [WORD_WIDTH-1:0] f_dest_id,
  output logic [WORD_WIDTH-1:0] f_cluster_id,
  output logic [WORD_WIDTH-1:0] f_energy_left,
  output logic [WORD_WIDTH-1:0] f_qvalue,
  output logic [2:0]            f_packet_type,
  output logic                  pkt_valid,
  input  logic                  pkt_ready,
  output logic                  no_route,
  output logic                  busy,
  output logic                  done
);

  // Count needs one extra bit so a full 2^ADDR_WIDTH table is representable.
  localparam int                    CW      = ADDR_WIDTH + 1;
  localparam logic [WORD_WIDTH-1:0] MAX_CNT = WORD_WIDTH'(1) << ADDR_WIDTH;

  state_t                state, state_nxt;
  logic [CW-1:0]         idx, cnt;
  logic [WORD_WIDTH-1:0] id_r, cluster_r, energy_r, q_r;
  logic [2:0]            type_r;
  logic [WORD_WIDTH-1:0] best_q, best_id;
  logic                  start, is_data_in, zero_cnt, last, cmp;

  assign start      = (state == S_IDLE) && en;
  assign is_data_in = (pkt_type == PKT_DATA);
  assign zero_cnt   = (m_neighbor_count == '0);
  assign last       = ((idx + CW'(1)) == cnt);
  assign cmp        = (state == S_CMP);

  assign busy    = (state != S_IDLE);
  assign rd_addr = idx[ADDR_WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    pkt_valid = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: if (en) state_nxt = (is_data_in && !zero_cnt) ? S_REQ : S_SEND;
      S_REQ: begin
        rd_en     = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: state_nxt = S_CMP;
      S_CMP:  state_nxt = last ? S_SEND : S_REQ;
      S_SEND: begin
        pkt_valid = 1'b1;
        if (pkt_ready) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      no_route <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start) begin
        idx      <= '0;
        no_route <= is_data_in && zero_cnt;
      end else if (cmp && !last) begin
        idx <= idx + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (start) begin
      id_r      <= my_id;
      cluster_r <= my_cluster_id;
      energy_r  <= my_energy;
      q_r       <= my_qvalue;
      type_r    <= pkt_type;
      cnt       <= (m_neighbor_count > MAX_CNT) ? CW'(MAX_CNT) : CW'(m_neighbor_count);
    end
  end

  qmax_tracker #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_qmax (
    .clk    (clk),
    .rst    (rst),
    .clr    (start),
    .cmp    (cmp),
    .first  (idx == '0),
    .cand_q (m_qvalue),
    .cand_id(m_source_id),
    .best_q (best_q),
    .best_id(best_id)
  );

  // Fields read as zero outside the offer window so idle/reset outputs stay clean.
  assign f_source_id   = pkt_valid ? id_r      : '0;
  assign f_cluster_id  = pkt_valid ? cluster_r : '0;
  assign f_energy_left = pkt_valid ? energy_r  : '0;
  assign f_qvalue      = pkt_valid ? q_r       : '0;
  assign f_packet_type = pkt_valid ? type_r    : '0;
  assign f_dest_id     = !pkt_valid ? '0 :
                         ((type_r == PKT_DATA) && !no_route) ? best_id : BCAST_ID;

endmodule

// File: tb/tb_qpacket_tx.sv
// Directed bench for qpacket_tx: HELLO/DATA packets, next-hop selection, ties,
// no-route, backpressure, mid-scan reset and neighbor-count clamping.
module tb_qpacket_tx;
  import qpacket_pkg::*;

  logic        clk = 1'b0, rst = 1'b1, en = 1'b0, pkt_ready = 1'b0;
  logic [2:0]  pkt_type = '0;
  logic [15:0] my_id = '0, my_cluster_id = '0, my_energy = '0, my_qvalue = '0;
  logic [15:0] m_neighbor_count = '0, m_source_id = '0, m_qvalue = '0;
  logic        rd_en, pkt_valid, no_route, busy, done;
  logic [10:0] rd_addr;
  logic [15:0] f_source_id, f_dest_id, f_cluster_id, f_energy_left, f_qvalue;
  logic [2:0]  f_packet_type;

  logic [15:0] mem_id [0:2047];
  logic [15:0] mem_q  [0:2047];
  logic [10:0] addr_log [$];
  int n_cmp = 0, n_fail = 0;

  qpacket_tx dut (
    .clk(clk), .rst(rst), .en(en), .pkt_type(pkt_type),
    .my_id(my_id), .my_cluster_id(my_cluster_id), .my_energy(my_energy), .my_qvalue(my_qvalue),
    .m_neighbor_count(m_neighbor_count), .rd_en(rd_en), .rd_addr(rd_addr),
    .m_source_id(m_source_id), .m_qvalue(m_qvalue),
    .f_source_id(f_source_id), .f_dest_id(f_dest_id), .f_cluster_id(f_cluster_id),
    .f_energy_left(f_energy_left), .f_qvalue(f_qvalue), .f_packet_type(f_packet_type),
    .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .no_route(no_route), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // One-cycle-latency neighbor table
  always @(posedge clk) begin
    if (rd_en) begin
      m_source_id <= mem_id[rd_addr];
      m_qvalue    <= mem_q[rd_addr];
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic launch(input logic [2:0] t, input logic [15:0] cnt, input logic [15:0] id);
    pkt_type = t; m_neighbor_count = cnt; my_id = id;
    my_cluster_id = id + 16'h0100; my_energy = id + 16'h0E00; my_qvalue = id + 16'h0A00;
    addr_log.delete();
    en = 1'b1;
  endtask

  task automatic wait_valid(output int lat);
    lat = -1;
    for (int c = 1; c <= 7000; c++) begin
      step();
      en = 1'b0;
      if (rd_en) addr_log.push_back(rd_addr);
      if (pkt_valid) begin lat = c; break; end
    end
    en = 1'b0;
  endtask

  task automatic set_mem(input int i, input logic [15:0] id, input logic [15:0] q);
    mem_id[i] = id; mem_q[i] = q;
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_cmp++;
    if ({busy, pkt_valid, done, rd_en, no_route} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, pkt_valid, done, rd_en, no_route});
    end
    n_cmp++;
    if ({rd_addr, f_dest_id, f_source_id, f_packet_type} !== 46'h0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h/%h/%h expected all 0", rd_addr, f_dest_id, f_source_id, f_packet_type);
    end
    rst = 1'b0; step();
  endtask

  task automatic test_hello();
    int lat;
    pkt_ready = 1'b1;
    launch(PKT_HELLO, 16'd3, 16'h0005);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL hello_latency: got %0d expected 1", lat); end
    n_cmp++;
    if ({f_dest_id, f_packet_type} !== {16'hFFFF, 3'd1}) begin
      n_fail++; $display("FAIL hello_dest_type: got %h/%0d expected ffff/1", f_dest_id, f_packet_type);
    end
    n_cmp++;
    if ({f_source_id, f_cluster_id, f_energy_left, f_qvalue} !== {16'h0005, 16'h0105, 16'h0E05, 16'h0A05}) begin
      n_fail++; $display("FAIL hello_fields: got %h %h %h %h expected 0005 0105 0e05 0a05",
                         f_source_id, f_cluster_id, f_energy_left, f_qvalue);
    end
    n_cmp++;
    if (addr_log.size() != 0) begin n_fail++; $display("FAIL hello_no_read: got %0d reads expected 0", addr_log.size()); end
    step();
    n_cmp++;
    if ({done, pkt_valid, busy} !== 3'b101) begin
      n_fail++; $display("FAIL hello_done: got done/valid/busy=%b expected 101", {done, pkt_valid, busy});
    end
    step();
    n_cmp++;
    if ({done, busy} !== 2'b00) begin n_fail++; $display("FAIL hello_idle: got done/busy=%b expected 00", {done, busy}); end
    // Unknown type codes go out as broadcast without a table scan
    launch(3'd5, 16'd2, 16'h0006);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 1, f_dest_id, f_packet_type, addr_log.size() == 0} !== {1'b1, 16'hFFFF, 3'd5, 1'b1}) begin
      n_fail++; $display("FAIL other_type: got lat=%0d dest=%h type=%0d reads=%0d expected 1 ffff 5 0",
                         lat, f_dest_id, f_packet_type, addr_log.size());
    end
    step(); step();
  endtask

  task automatic test_data3();
    int lat;
    logic [32:0] seq;
    set_mem(0, 16'h000A, 16'h0100); set_mem(1, 16'h000B, 16'h0300); set_mem(2, 16'h000C, 16'h0200);
    pkt_ready = 1'b1;
    launch(PKT_DATA, 16'd3, 16'h0007);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 10) begin n_fail++; $display("FAIL data3_latency: got %0d expected 10", lat); end
    seq = (addr_log.size() == 3) ? {addr_log[0], addr_log[1], addr_log[2]} : '1;
    n_cmp++;
    if (seq !== {11'd0, 11'd1, 11'd2}) begin
      n_fail++; $display("FAIL data3_addr_seq: got %0d reads seq=%h expected 0,1,2", addr_log.size(), seq);
    end
    n_cmp++;
    if ({f_dest_id, f_packet_type, no_route} !== {16'h000B, 3'd2, 1'b0}) begin
      n_fail++; $display("FAIL data3_dest: got %h/%0d/%b expected 000b/2/0", f_dest_id, f_packet_type, no_route);
    end
    step();
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL data3_done: got %b expected 1", done); end
    step();
  endtask

  task automatic test_tie();
    int lat;
    set_mem(0, 16'h000A, 16'h0100); set_mem(1, 16'h000B, 16'h0300); set_mem(2, 16'h000C, 16'h0300);
    launch(PKT_DATA, 16'd3, 16'h0008);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 10, f_dest_id} !== {1'b1, 16'h000B}) begin
      n_fail++; $display("FAIL tie_lower_idx: got lat=%0d dest=%h expected 10/000b", lat, f_dest_id);
    end
    step(); step();
    // All-zero Q values: the first entry must still win
    set_mem(0, 16'h0021, 16'h0000); set_mem(1, 16'h0022, 16'h0000);
    launch(PKT_DATA, 16'd2, 16'h0009);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 7, f_dest_id} !== {1'b1, 16'h0021}) begin
      n_fail++; $display("FAIL zero_q_first: got lat=%0d dest=%h expected 7/0021", lat, f_dest_id);
    end
    step(); step();
  endtask

  task automatic test_no_route();
    int lat;
    launch(PKT_DATA, 16'd0, 16'h0010);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 1, f_dest_id, no_route, addr_log.size() == 0} !== {1'b1, 16'hFFFF, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL no_route_pkt: got lat=%0d dest=%h no_route=%b reads=%0d expected 1 ffff 1 0",
                         lat, f_dest_id, no_route, addr_log.size());
    end
    step(); step();
    n_cmp++;
    if ({busy, no_route} !== 2'b01) begin n_fail++; $display("FAIL no_route_hold: got busy/no_route=%b expected 01", {busy, no_route}); end
    launch(PKT_HELLO, 16'd0, 16'h0011);
    wait_valid(lat);
    n_cmp++;
    if (no_route !== 1'b0) begin n_fail++; $display("FAIL no_route_clear: got %b expected 0", no_route); end
    step(); step();
  endtask

  task automatic test_backpressure();
    int lat;
    logic [82:0] exp_fields;
    exp_fields = {16'h0021, 16'hFFFF, 16'h0121, 16'h0E21, 16'h0A21, 3'd1};
    pkt_ready = 1'b0;
    launch(PKT_HELLO, 16'd0, 16'h0021);
    wait_valid(lat);
    n_cmp++;
    if (lat !== 1) begin n_fail++; $display("FAIL bp_latency: got %0d expected 1", lat); end
    for (int i = 0; i < 5; i++) begin
      en = 1'b1; my_id = 16'hBEEF; pkt_type = PKT_DATA; m_neighbor_count = 16'd5; my_energy = 16'h1234;
      step();
      n_cmp++;
      if ({pkt_valid, done, f_source_id, f_dest_id, f_cluster_id, f_energy_left, f_qvalue, f_packet_type} !==
          {1'b1, 1'b0, exp_fields}) begin
        n_fail++; $display("FAIL bp_hold_%0d: got valid=%b done=%b src=%h dest=%h energy=%h expected 1 0 0021 ffff 0e21",
                           i, pkt_valid, done, f_source_id, f_dest_id, f_energy_left);
      end
    end
    en = 1'b0; pkt_ready = 1'b1;
    step();
    n_cmp++;
    if ({done, pkt_valid} !== 2'b10) begin n_fail++; $display("FAIL bp_done: got done/valid=%b expected 10", {done, pkt_valid}); end
    step();
    n_cmp++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL bp_en_ignored: got busy/done=%b expected 00", {busy, done}); end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic saw_done;
    set_mem(0, 16'h0031, 16'h0010); set_mem(1, 16'h0032, 16'h0020);
    set_mem(2, 16'h0033, 16'h0030); set_mem(3, 16'h0034, 16'h0040);
    pkt_ready = 1'b1;
    launch(PKT_DATA, 16'd4, 16'h0040);
    step(); en = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    step();
    n_cmp++;
    if ({busy, pkt_valid, done, rd_en, no_route} !== 5'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got %b expected 00000", {busy, pkt_valid, done, rd_en, no_route});
    end
    n_cmp++;
    if ({rd_addr, f_dest_id} !== 27'h0) begin n_fail++; $display("FAIL rst_mid_data: got addr=%0d dest=%h expected 0/0000", rd_addr, f_dest_id); end
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (4) begin step(); saw_done |= done | pkt_valid | busy; end
    n_cmp++;
    if (saw_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_abort: got activity=%b expected 0", saw_done); end
    launch(PKT_DATA, 16'd2, 16'h0041);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 7, addr_log.size() == 2, f_dest_id} !== {1'b1, 1'b1, 16'h0032}) begin
      n_fail++; $display("FAIL rst_restart: got lat=%0d reads=%0d dest=%h expected 7 2 0032", lat, addr_log.size(), f_dest_id);
    end
    n_cmp++;
    if ((addr_log.size() > 0 ? addr_log[0] : 11'h7FF) !== 11'd0) begin
      n_fail++; $display("FAIL rst_restart_idx: got first addr %0d expected 0", addr_log.size() > 0 ? addr_log[0] : 11'h7FF);
    end
    step(); step();
  endtask

  task automatic test_clamp();
    int lat;
    for (int i = 0; i < 2048; i++) set_mem(i, 16'(i) + 16'h1000, {8'h00, 8'(i)});
    set_mem(100, 16'h1064, 16'hFFFF);
    launch(PKT_DATA, 16'h1000, 16'h0050);
    wait_valid(lat);
    n_cmp++;
    if ({lat == 6145, addr_log.size() == 2048} !== 2'b11) begin
      n_fail++; $display("FAIL clamp_len: got lat=%0d reads=%0d expected 6145 2048", lat, addr_log.size());
    end
    n_cmp++;
    if (f_dest_id !== 16'h1064) begin n_fail++; $display("FAIL clamp_dest: got %h expected 1064", f_dest_id); end
    step(); step();
  endtask

  initial begin
    test_reset();
    test_hello();
    test_data3();
    test_tie();
    test_no_route();
    test_backpressure();
    test_reset_mid();
    test_clamp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
